// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Sequential radix-2 Booth multiplier, 16x16 -> 32 bits, one Booth step
//   per clock. Operands are captured with ld, a run is started with ld_PP,
//   and the result is held on product until the next completion or reset.
//
//   Optional build macro: BOOTH_SIGNED_EN
//     undefined : operands zero-extended to 17 bits, 17 steps, unsigned product
//     defined   : operands sign-extended to 17 bits, 16 steps, signed product
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   synchronous, active-low
//   in_A     in   16  multiplicand
//   in_B     in   16  multiplier
//   ld       in   1   capture in_A/in_B (IDLE only)
//   ld_PP    in   1   start (IDLE) or restart (RUN) a multiply
//   product  out  32  result register
module booth_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  input  logic        ld,
  input  logic        ld_PP,
  output logic [31:0] product
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef BOOTH_SIGNED_EN
  // Bit 15 already carries the sign, so 16 steps cover the whole multiplier.
  localparam logic [4:0] STEPS = 5'd16;
`else
  localparam logic [4:0] STEPS = 5'd17;
`endif

  // Booth working register {ACC, Q, Q-1}, shifted right as one 35-bit value.
  typedef struct packed {
    logic [16:0] acc;
    logic [16:0] q;
    logic        qm1;
  } booth_t;

  logic [0:0]  state;
  logic [16:0] m_reg;
  logic [16:0] b_reg;
  booth_t      br;
  booth_t      br_next;
  logic [4:0]  count;
  logic [16:0] acc_sum;
  logic [31:0] prod_sel;

  function automatic logic [16:0] ext17(input logic [15:0] v);
`ifdef BOOTH_SIGNED_EN
    return {v[15], v};
`else
    return {1'b0, v};
`endif
  endfunction

  // One Booth step: conditional add/sub of M into ACC, then arithmetic
  // right shift of the whole register. The 17th bit keeps ACC from
  // overflowing for any 16-bit operand pair.
  always_comb begin
    acc_sum = br.acc;
    case ({br.q[0], br.qm1})
      2'b01:   acc_sum = br.acc + m_reg;
      2'b10:   acc_sum = br.acc - m_reg;
      default: acc_sum = br.acc;
    endcase
    br_next.acc = {acc_sum[16], acc_sum[16:1]};
    br_next.q   = {acc_sum[0], br.q[16:1]};
    br_next.qm1 = br.q[0];
  end

  // Unsigned: 17 shifts leave the product right-aligned in {ACC,Q}.
  // Signed: only 16 shifts happen, so the product sits one bit higher and
  // Q[0] still holds the unconsumed (sign) bit of the multiplier.
`ifdef BOOTH_SIGNED_EN
  assign prod_sel = {br_next.acc[15:0], br_next.q[16:1]};
`else
  assign prod_sel = {br_next.acc[14:0], br_next.q};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      m_reg   <= '0;
      b_reg   <= '0;
      br      <= '0;
      count   <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (ld) begin
        m_reg <= ext17(in_A);
        b_reg <= ext17(in_B);
      end
      if (ld_PP) begin
        // Same-cycle ld bypasses the operand registers.
        br.acc <= '0;
        br.q   <= ld ? ext17(in_B) : b_reg;
        br.qm1 <= 1'b0;
        count  <= STEPS;
        state  <= RUN;
      end
    end else if (ld_PP) begin
      // Restart from the held operands; product keeps its old value.
      br.acc <= '0;
      br.q   <= b_reg;
      br.qm1 <= 1'b0;
      count  <= STEPS;
    end else begin
      br    <= br_next;
      count <= count - 5'd1;
      if (count == 5'd1) begin
        product <= prod_sel;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;

`ifdef BOOTH_SIGNED_EN
  localparam int unsigned LAT = 16;
`else
  localparam int unsigned LAT = 17;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        ld;
  logic        ld_PP;
  logic [31:0] product;

  booth_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .in_A    (in_A),
    .in_B    (in_B),
    .ld      (ld),
    .ld_PP   (ld_PP),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          armed = 1'b0;
  logic [31:0] held = '0;
  logic [15:0] mA = '0;
  logic [15:0] mB = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the product of the latched operands, plain arithmetic.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea, eb;
`ifdef BOOTH_SIGNED_EN
    ea = {{16{a[15]}}, a};
    eb = {{16{b[15]}}, b};
`else
    ea = {16'b0, a};
    eb = {16'b0, b};
`endif
    return ea * eb;
  endfunction

  // Monitor: product must equal the last result due by this cycle, every cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      held  = sb[0].val;
      armed = 1'b1;
      void'(sb.pop_front());
    end
    if (armed) begin
      checks++;
      if (product !== held) begin
        errors++;
        $display("FAIL product cyc=%0d got=%h expected=%h", cyc, product, held);
      end
    end
  end

  task automatic do_ld(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_A = a; in_B = b; ld = 1'b1;
    mA = a; mB = b;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    ld_PP = 1'b1;
    sb.push_back('{due: cyc + 1 + LAT, val: model(mA, mB)});
    @(negedge clk);
    ld_PP = 1'b0;
  endtask

  task automatic ld_go(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_A = a; in_B = b; ld = 1'b1; ld_PP = 1'b1;
    mA = a; mB = b;
    sb.push_back('{due: cyc + 1 + LAT, val: model(mA, mB)});
    @(negedge clk);
    ld = 1'b0; ld_PP = 1'b0;
  endtask

  task automatic wait_done();
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    logic [15:0] a, b;
    reset = 1'b0; ld = 1'b0; ld_PP = 1'b0; in_A = '0; in_B = '0;
    sb.push_back('{due: 1, val: 32'h0});
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    do_ld(16'd3, 16'd5);          go(); wait_done();
    do_ld(16'hFFFF, 16'hFFFF);    go(); wait_done();
    do_ld(16'h1234, 16'h0000);    go(); wait_done();
    do_ld(16'h5A5A, 16'h0003);    go(); wait_done();
    do_ld(16'h0000, 16'hBEEF);    go(); wait_done();
    do_ld(16'h8000, 16'h8000);    go(); wait_done();

    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_ld(a, b);
      @(negedge clk);
      go();
      wait_done();
    end

    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      ld_go(a, b);
      wait_done();
    end

    // ld during a run is ignored; ld_PP during a run restarts it.
    do_ld(16'h0102, 16'h0304);
    go();
    repeat (2) @(negedge clk);
    in_A = 16'hAAAA; in_B = 16'h5555; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    ld_PP = 1'b1;
    sb.delete();
    sb.push_back('{due: cyc + 1 + LAT, val: model(mA, mB)});
    @(negedge clk);
    ld_PP = 1'b0;
    wait_done();
    go(); wait_done();

    // Reset 8 clocks into a run aborts it and clears everything.
    do_ld(16'd7, 16'd9);
    go();
    repeat (7) @(negedge clk);
    reset = 1'b0;
    mA = '0; mB = '0;
    sb.delete();
    sb.push_back('{due: cyc + 1, val: 32'h0});
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    do_ld(16'd7, 16'd9);          go(); wait_done();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
